// File: rtl/decode_pkg.sv
// Shared decode definitions: immediate-format and result-source encodings,
// plus the RV32I immediate extractor used by the decode stage.
package decode_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_e;

    // Returns the 32-bit sign-extended immediate; callers widen it to XLEN
    // with a signed size cast so the same function serves every XLEN.
    function automatic logic [31:0] imm_extend(input logic [31:0] instr,
                                               input logic [2:0]  immSrc);
        logic [31:0] imm;
        imm = '0;
        case (immSrc)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_p_reg_file_bp.sv
// Architectural register file: two combinational read ports, one write port,
// hardwired x0 and same-cycle write-through bypass to both read ports.
module reg_file_bp
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   a1_i,
    input  logic [AW-1:0]   a2_i,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wrEn;

    assign wrEn = we_i && (wa_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrEn) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // x0 never reads storage, so a write aimed at it can never leak out.
    always_comb begin
        rd1_o = '0;
        rd2_o = '0;
        if (a1_i != '0) begin
            rd1_o = (wrEn && (wa_i == a1_i)) ? wd_i : regs_q[a1_i];
        end
        if (a2_i != '0) begin
            rd2_o = (wrEn && (wa_i == a2_i)) ? wd_i : regs_q[a2_i];
        end
    end

endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: register file read, immediate extension and the ID/EX
// pipeline register with valid, stall-hold, flush-bubble and operand patch.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ALUCTL_W = 3,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                StallE,
    input  logic                FlushE,
    input  logic                ValidD,
    input  logic [31:0]         instrD,
    input  logic [XLEN-1:0]     PCD,
    input  logic [XLEN-1:0]     PCPlus4D,
    input  logic [AW-1:0]       RdW,
    input  logic [XLEN-1:0]     ResultW,
    input  logic                RegWriteW,
    input  logic                RegWriteD,
    input  logic                MemWriteD,
    input  logic                ALUSrcD,
    input  logic                BranchD,
    input  logic                JumpD,
    input  logic [1:0]          ResultSrcD,
    input  logic [ALUCTL_W-1:0] ALUControlD,
    input  logic [2:0]          ImmSrcD,
    output logic [XLEN-1:0]     RD1E,
    output logic [XLEN-1:0]     RD2E,
    output logic [XLEN-1:0]     PCE,
    output logic [XLEN-1:0]     PCPlus4E,
    output logic [XLEN-1:0]     ExtImmE,
    output logic [AW-1:0]       Rs1E,
    output logic [AW-1:0]       Rs2E,
    output logic [AW-1:0]       RdE,
    output logic                ValidE,
    output logic                RegWriteE,
    output logic                MemWriteE,
    output logic                ALUSrcE,
    output logic                BranchE,
    output logic                JumpE,
    output logic [1:0]          ResultSrcE,
    output logic [ALUCTL_W-1:0] ALUControlE
);

    logic [AW-1:0]       rs1D, rs2D, rdD;
    logic [XLEN-1:0]     rd1D, rd2D, extImmD;
    logic                patch1, patch2;
    logic                unusedOpcode;

    logic [XLEN-1:0]     rd1_q, rd2_q, pc_q, pc4_q, imm_q;
    logic [AW-1:0]       rs1_q, rs2_q, rdIdx_q;
    logic                valid_q, regWrite_q, memWrite_q, aluSrc_q, branch_q, jump_q;
    logic [1:0]          resultSrc_q;
    logic [ALUCTL_W-1:0] aluCtl_q;

    assign rs1D         = instrD[15 +: AW];
    assign rs2D         = instrD[20 +: AW];
    assign rdD          = instrD[7 +: AW];
    assign extImmD      = XLEN'($signed(imm_extend(instrD, ImmSrcD)));
    assign unusedOpcode = ^instrD[6:0];

    reg_file_bp #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regFile (
        .clk   (clk),
        .rst   (rst),
        .a1_i  (rs1D),
        .a2_i  (rs2D),
        .we_i  (RegWriteW),
        .wa_i  (RdW),
        .wd_i  (ResultW),
        .rd1_o (rd1D),
        .rd2_o (rd2D)
    );

    // A held instruction must pick up writebacks that land while it waits,
    // otherwise it would leave the stall carrying stale operands.
    assign patch1 = RegWriteW && (RdW != '0) && (RdW == rs1_q);
    assign patch2 = RegWriteW && (RdW != '0) && (RdW == rs2_q);

    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            valid_q     <= 1'b0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            pc_q        <= '0;
            pc4_q       <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rdIdx_q     <= '0;
            regWrite_q  <= 1'b0;
            memWrite_q  <= 1'b0;
            aluSrc_q    <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            resultSrc_q <= '0;
            aluCtl_q    <= '0;
        end else if (StallE) begin
            if (patch1) rd1_q <= ResultW;
            if (patch2) rd2_q <= ResultW;
        end else begin
            valid_q     <= ValidD;
            rd1_q       <= rd1D;
            rd2_q       <= rd2D;
            pc_q        <= PCD;
            pc4_q       <= PCPlus4D;
            imm_q       <= extImmD;
            rs1_q       <= rs1D;
            rs2_q       <= rs2D;
            rdIdx_q     <= rdD;
            regWrite_q  <= ValidD & RegWriteD;
            memWrite_q  <= ValidD & MemWriteD;
            aluSrc_q    <= ValidD & ALUSrcD;
            branch_q    <= ValidD & BranchD;
            jump_q      <= ValidD & JumpD;
            resultSrc_q <= ValidD ? ResultSrcD : 2'b00;
            aluCtl_q    <= ValidD ? ALUControlD : '0;
        end
    end

    assign ValidE      = valid_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc4_q;
    assign ExtImmE     = imm_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rdIdx_q;
    assign RegWriteE   = regWrite_q;
    assign MemWriteE   = memWrite_q;
    assign ALUSrcE     = aluSrc_q;
    assign BranchE     = branch_q;
    assign JumpE       = jump_q;
    assign ResultSrcE  = resultSrc_q;
    assign ALUControlE = aluCtl_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: a 64-bit/32-reg DUT checked every cycle against a
// behavioural model, plus a 32-bit/16-reg DUT for index truncation.
module tb_decode_stage_p;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst, StallE, FlushE, ValidD;
    logic [31:0] instrD;
    logic [63:0] PCD, PCPlus4D, ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic        RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD, ImmSrcD;

    logic [63:0] RD1E, RD2E, PCE, PCPlus4E, ExtImmE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ValidE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;

    logic [31:0] sRD1E, sRD2E, sPCE, sPCPlus4E, sExtImmE;
    logic [3:0]  sRs1E, sRs2E, sRdE;
    logic        sValidE, sRegWriteE, sMemWriteE, sALUSrcE, sBranchE, sJumpE;
    logic [1:0]  sResultSrcE;
    logic [2:0]  sALUControlE;

    int checksTotal  = 0;
    int checksPassed = 0;
    logic armed = 1'b0;
    logic [63:0] pcVal;

    always #5 clk = ~clk;

    decode_stage_p #(.XLEN(64), .NREGS(32), .ALUCTL_W(3)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .RdW(RdW), .ResultW(ResultW),
        .RegWriteW(RegWriteW), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
        .ALUControlD(ALUControlD), .ImmSrcD(ImmSrcD),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ExtImmE(ExtImmE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE)
    );

    decode_stage_p #(.XLEN(32), .NREGS(16), .ALUCTL_W(3)) dutSmall (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .instrD(instrD), .PCD(PCD[31:0]), .PCPlus4D(PCPlus4D[31:0]), .RdW(RdW[3:0]),
        .ResultW(ResultW[31:0]), .RegWriteW(RegWriteW), .RegWriteD(RegWriteD),
        .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .BranchD(BranchD), .JumpD(JumpD),
        .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .ImmSrcD(ImmSrcD),
        .RD1E(sRD1E), .RD2E(sRD2E), .PCE(sPCE), .PCPlus4E(sPCPlus4E), .ExtImmE(sExtImmE),
        .Rs1E(sRs1E), .Rs2E(sRs2E), .RdE(sRdE), .ValidE(sValidE), .RegWriteE(sRegWriteE),
        .MemWriteE(sMemWriteE), .ALUSrcE(sALUSrcE), .BranchE(sBranchE), .JumpE(sJumpE),
        .ResultSrcE(sResultSrcE), .ALUControlE(sALUControlE)
    );

    // Control bundle order: RegWrite, MemWrite, ALUSrc, Branch, Jump, ResultSrc, ALUControl.
    localparam logic [9:0] CTL_ALL  = 10'h3FF;
    localparam logic [9:0] CTL_ADDI = 10'b1_0_1_0_0_00_000;
    localparam logic [9:0] CTL_ADD  = 10'b1_0_0_0_0_00_010;
    localparam logic [9:0] CTL_STL  = 10'b1_0_0_0_0_10_101;

    logic [9:0] ctlD, ctlE;
    assign ctlD = {RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD, ResultSrcD, ALUControlD};
    assign ctlE = {RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE};

    typedef struct {
        logic        valid;
        logic [63:0] rd1, rd2, pc, pc4, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [9:0]  ctl;
    } eState_t;

    eState_t     modelE;
    logic [63:0] modelRegs [32];

    function automatic eState_t bubble();
        eState_t s;
        s.valid = 1'b0; s.rd1 = '0; s.rd2 = '0; s.pc = '0; s.pc4 = '0; s.imm = '0;
        s.rs1 = '0; s.rs2 = '0; s.rd = '0; s.ctl = '0;
        return s;
    endfunction

    // Immediates as signed field values scaled by their implicit shift.
    function automatic logic [63:0] modelImm(input logic [31:0] ins, input logic [2:0] sel);
        longint v;
        case (sel)
            3'd0:    v = longint'($signed(ins[31:20]));
            3'd1:    v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd2:    v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
            3'd3:    v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
            3'd4:    v = longint'($signed(ins[31:12])) * 4096;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] readReg(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (RegWriteW && RdW == a) return ResultW;
        return modelRegs[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            modelE = bubble();
            for (int i = 0; i < 32; i++) modelRegs[i] = '0;
        end else begin
            if (FlushE) begin
                modelE = bubble();
            end else if (StallE) begin
                if (RegWriteW && RdW != 5'd0 && RdW == modelE.rs1) modelE.rd1 = ResultW;
                if (RegWriteW && RdW != 5'd0 && RdW == modelE.rs2) modelE.rd2 = ResultW;
            end else begin
                modelE.valid = ValidD;
                modelE.rd1   = readReg(instrD[19:15]);
                modelE.rd2   = readReg(instrD[24:20]);
                modelE.pc    = PCD;
                modelE.pc4   = PCPlus4D;
                modelE.imm   = modelImm(instrD, ImmSrcD);
                modelE.rs1   = instrD[19:15];
                modelE.rs2   = instrD[24:20];
                modelE.rd    = instrD[11:7];
                modelE.ctl   = ValidD ? ctlD : 10'd0;
            end
            if (RegWriteW && RdW != 5'd0) modelRegs[RdW] = ResultW;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        checksTotal++;
        if (act === want) checksPassed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
    endtask

    // Outputs only move on the rising edge, so the falling edge is a stable sample point.
    always @(negedge clk) begin
        if (armed) begin
            checkOutput("ValidE",  64'(ValidE), 64'(modelE.valid));
            checkOutput("RD1E",    RD1E, modelE.rd1);
            checkOutput("RD2E",    RD2E, modelE.rd2);
            checkOutput("PCE",     PCE, modelE.pc);
            checkOutput("PCPlus4E", PCPlus4E, modelE.pc4);
            checkOutput("ExtImmE", ExtImmE, modelE.imm);
            checkOutput("idxE",    64'({Rs1E, Rs2E, RdE}), 64'({modelE.rs1, modelE.rs2, modelE.rd}));
            checkOutput("ctlE",    64'(ctlE), 64'(modelE.ctl));
            checkOutput("small.idxE", 64'({sRs1E, sRs2E, sRdE}),
                        64'({modelE.rs1[3:0], modelE.rs2[3:0], modelE.rd[3:0]}));
            checkOutput("small.ExtImmE", 64'(sExtImmE), 64'(modelE.imm[31:0]));
            checkOutput("small.ValidE", 64'(sValidE), 64'(modelE.valid));
        end
    end

    task automatic applyStimulus(input logic rstV, input logic [31:0] ins, input logic vld,
                                 input logic [2:0] immSel, input logic [9:0] ctl,
                                 input logic stall, input logic flush, input logic we,
                                 input logic [4:0] rdW, input logic [63:0] res);
        @(negedge clk);
        rst        = rstV;
        instrD     = ins;
        ValidD     = vld;
        ImmSrcD    = immSel;
        {RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD, ResultSrcD, ALUControlD} = ctl;
        StallE     = stall;
        FlushE     = flush;
        RegWriteW  = we;
        RdW        = rdW;
        ResultW    = res;
        PCD        = pcVal;
        PCPlus4D   = pcVal + 64'd4;
        pcVal      = pcVal + 64'd4;
        @(posedge clk);
        #1;
    endtask

    initial begin
        pcVal = 64'h1000;
        rst = 1'b1; StallE = 1'b0; FlushE = 1'b0; ValidD = 1'b0; instrD = '0;
        PCD = '0; PCPlus4D = '0; ResultW = '0; RdW = '0; RegWriteW = 1'b0;
        {RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD, ResultSrcD, ALUControlD} = '0;
        ImmSrcD = '0;
        @(posedge clk);
        #1;
        armed = 1'b1;
        checkOutput("rst.ValidE", 64'(ValidE), 64'd0);
        checkOutput("rst.RD1E", RD1E, 64'd0);
        checkOutput("rst.RegWriteE", 64'(RegWriteE), 64'd0);

        $display("[TB] register file write, x0 and immediate");
        applyStimulus(0, 32'h0000_0000, 0, IMM_I, 10'd0,    0, 0, 1, 5'd5, 64'h1234);
        applyStimulus(0, 32'h0050_0093, 1, IMM_I, CTL_ADDI, 0, 0, 1, 5'd0, 64'hFFFF);
        checkOutput("addi.RD1E", RD1E, 64'd0);
        checkOutput("addi.ExtImmE", ExtImmE, 64'd5);
        checkOutput("addi.RdE", 64'(RdE), 64'd1);
        checkOutput("addi.RegWriteE", 64'(RegWriteE), 64'd1);
        applyStimulus(0, 32'h0002_8113, 1, IMM_I, CTL_ADDI, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("readX5.RD1E", RD1E, 64'h1234);
        checkOutput("readX0.RD2E", RD2E, 64'd0);

        $display("[TB] write-through bypass");
        applyStimulus(0, 32'h0051_8233, 1, IMM_I, CTL_ADD, 0, 0, 1, 5'd3, 64'hDEAD_BEEF);
        checkOutput("bypass.RD1E", RD1E, 64'hDEAD_BEEF);
        checkOutput("bypass.RD2E", RD2E, 64'h1234);
        applyStimulus(0, 32'h0031_8233, 1, IMM_I, CTL_ADD, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("stored.RD2E", RD2E, 64'hDEAD_BEEF);

        $display("[TB] immediate formats");
        applyStimulus(0, 32'hFFF0_0093, 1, IMM_I, CTL_ADDI, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("immI", ExtImmE, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(0, 32'h8000_00B7, 1, IMM_U, CTL_ADDI, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("immU", ExtImmE, 64'hFFFF_FFFF_8000_0000);
        applyStimulus(0, 32'h0000_00E3, 1, IMM_B, CTL_ADD, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("immB.pos", ExtImmE, 64'h800);
        applyStimulus(0, 32'hFE00_0EE3, 1, IMM_B, CTL_ADD, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("immB.neg", ExtImmE, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(0, 32'hFFDF_F0EF, 1, IMM_J, CTL_ADD, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("immJ.neg", ExtImmE, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(0, 32'h0010_006F, 1, IMM_J, CTL_ADD, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("immJ.pos", ExtImmE, 64'h800);
        applyStimulus(0, 32'hFE50_2C23, 1, IMM_S, CTL_ADD, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("immS", ExtImmE, 64'hFFFF_FFFF_FFFF_FFF8);
        applyStimulus(0, 32'hFFFF_FFFF, 1, 3'd5, CTL_ADD, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("immNone", ExtImmE, 64'd0);

        $display("[TB] stall hold with operand patch");
        applyStimulus(0, 32'h0071_8233, 1, IMM_I, CTL_STL, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("stl.load.RD2E", RD2E, 64'd0);
        applyStimulus(0, 32'hFFFF_FFFF, 1, IMM_U, CTL_ALL, 1, 0, 1, 5'd7, 64'hA5);
        checkOutput("stl.patch.RD2E", RD2E, 64'hA5);
        applyStimulus(0, 32'hFFFF_FFFF, 1, IMM_U, CTL_ALL, 1, 0, 0, 5'd0, 64'd0);
        applyStimulus(0, 32'hFFFF_FFFF, 1, IMM_U, CTL_ALL, 1, 0, 1, 5'd3, 64'h77);
        checkOutput("stl.RD2E", RD2E, 64'hA5);
        checkOutput("stl.RD1E", RD1E, 64'h77);
        checkOutput("stl.ExtImmE", ExtImmE, 64'd7);
        checkOutput("stl.RdE", 64'(RdE), 64'd4);
        checkOutput("stl.ALUControlE", 64'(ALUControlE), 64'd5);
        checkOutput("stl.ResultSrcE", 64'(ResultSrcE), 64'd2);
        checkOutput("stl.MemWriteE", 64'(MemWriteE), 64'd0);

        $display("[TB] flush priority and invalid load");
        applyStimulus(0, 32'h0051_8233, 1, IMM_I, CTL_ALL, 1, 1, 0, 5'd0, 64'd0);
        checkOutput("flush.ValidE", 64'(ValidE), 64'd0);
        checkOutput("flush.RegWriteE", 64'(RegWriteE), 64'd0);
        checkOutput("flush.MemWriteE", 64'(MemWriteE), 64'd0);
        checkOutput("flush.RD1E", RD1E, 64'd0);
        applyStimulus(0, 32'h0051_8233, 0, IMM_I, CTL_ALL, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("inval.ValidE", 64'(ValidE), 64'd0);
        checkOutput("inval.ctl", 64'(ctlE), 64'd0);
        checkOutput("inval.RD1E", RD1E, 64'h77);
        checkOutput("inval.RD2E", RD2E, 64'h1234);
        checkOutput("inval.Rs1E", 64'(Rs1E), 64'd3);

        $display("[TB] truncated register indices");
        applyStimulus(0, 32'h0128_8233, 1, IMM_I, CTL_ALL, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("trunc.Rs1E", 64'(Rs1E), 64'd17);
        checkOutput("trunc.small.Rs1E", 64'(sRs1E), 64'd1);
        checkOutput("trunc.small.Rs2E", 64'(sRs2E), 64'd2);

        $display("[TB] reset during stall");
        applyStimulus(1, 32'hFFFF_FFFF, 1, IMM_U, CTL_ALL, 1, 0, 1, 5'd7, 64'h55);
        checkOutput("rstStl.ValidE", 64'(ValidE), 64'd0);
        checkOutput("rstStl.ExtImmE", ExtImmE, 64'd0);
        checkOutput("rstStl.PCE", PCE, 64'd0);
        checkOutput("rstStl.RegWriteE", 64'(RegWriteE), 64'd0);
        applyStimulus(0, 32'h0051_8233, 1, IMM_I, CTL_ADD, 0, 0, 0, 5'd0, 64'd0);
        checkOutput("postRst.ValidE", 64'(ValidE), 64'd1);
        checkOutput("postRst.RD2E", RD2E, 64'd0);
        checkOutput("postRst.RD1E", RD1E, 64'd0);

        applyStimulus(0, 32'h0000_0000, 0, IMM_I, 10'd0, 0, 0, 0, 5'd0, 64'd0);
        applyStimulus(0, 32'h0000_0000, 0, IMM_I, 10'd0, 0, 0, 0, 5'd0, 64'd0);
        @(negedge clk);
        #1;
        armed = 1'b0;
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
